// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: scan coordinates, display enable, syncs and frame pacing.
// All outputs are registered decodes of the pre-increment (hc, vc) position.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       blank_d, hs_d, vs_d, frame_start_d;
  logic [7:0] frame_count_d;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == HLast) begin
      hc_d = 10'd0;
      vc_d = (vc_q == VLast) ? 10'd0 : vc_q + 10'd1;
    end
  end

  always_comb begin
    blank_d       = (hc_q < HVis) && (vc_q < VVis);
    hs_d          = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
    vs_d          = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
    frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0);
    frame_count_d = frame_start_d ? frame_count + 8'd1 : frame_count;
  end

  // pix_en gates every register, so a stall freezes frame_start as well.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q        <= 10'd0;
      vc_q        <= 10'd0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else if (pix_en) begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      DrawX       <= hc_q;
      DrawY       <= vc_q;
      blank       <= blank_d;
      hs          <= hs_d;
      vs          <= vs_d;
      frame_start <= frame_start_d;
      frame_count <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-raster instance for full-frame and wrap coverage,
// and a default 640x480 instance for line-level checks, both against an arithmetic model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    int   adv;
    out_t exp;
  } vec_t;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en  = 1'b0;

  logic [9:0] s_x, s_y, d_x, d_y;
  logic       s_blank, s_hs, s_vs, s_fs, d_blank, d_hs, d_vs, d_fs;
  logic [7:0] s_fc, d_fc;

  int errors = 0;
  int checks = 0;
  int n      = 0;
  int wraps  = 0;

  always #5 vga_clk = ~vga_clk;

  // Small raster: 15 x 10, frame = 150 enabled cycles.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen u_dflt (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(d_x), .DrawY(d_y), .blank(d_blank), .hs(d_hs), .vs(d_vs),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  // Expected outputs after n enabled edges since reset release.
  function automatic out_t model(input int cnt, input int hv, input int hfp, input int hsy,
                                 input int hbp, input int vv, input int vfp, input int vsy,
                                 input int vbp);
    out_t o;
    int ht, ft, p, x, y;
    if (cnt == 0) return '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1,
                           fs: 1'b0, fc: 8'd0};
    ht = hv + hfp + hsy + hbp;
    ft = ht * (vv + vfp + vsy + vbp);
    p  = (cnt - 1) % ft;
    x  = p % ht;
    y  = p / ht;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < hv) && (y < vv);
    o.hs    = !((x >= hv + hfp) && (x < hv + hfp + hsy));
    o.vs    = !((y >= vv + vfp) && (y < vv + vfp + vsy));
    o.fs    = (p == 0);
    o.fc    = 8'(((cnt - 1) / ft + 1) % 256);
    return o;
  endfunction

  function automatic out_t mk(input int x, input int y, input logic b, input logic h,
                              input logic v, input logic f, input int c);
    return '{x: 10'(x), y: 10'(y), blank: b, hs: h, vs: v, fs: f, fc: 8'(c)};
  endfunction

  task automatic cmp(input string name, input out_t got, input out_t req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s n=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d required x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
               name, n, got.x, got.y, got.blank, got.hs, got.vs, got.fs, got.fc,
               req.x, req.y, req.blank, req.hs, req.vs, req.fs, req.fc);
    end
  endtask

  function automatic out_t small_out();
    return '{x: s_x, y: s_y, blank: s_blank, hs: s_hs, vs: s_vs, fs: s_fs, fc: s_fc};
  endfunction

  function automatic out_t dflt_out();
    return '{x: d_x, y: d_y, blank: d_blank, hs: d_hs, vs: d_vs, fs: d_fs, fc: d_fc};
  endfunction

  task automatic check_both();
    cmp("small_model", small_out(), model(n, 8, 2, 3, 2, 6, 1, 2, 1));
    cmp("dflt_model", dflt_out(), model(n, 640, 16, 96, 48, 480, 10, 2, 33));
  endtask

  // Drive on the falling edge, advance one rising edge, check on the next falling edge.
  task automatic tick(input logic en);
    logic [7:0] prev_fc;
    prev_fc = s_fc;
    pix_en  = en;
    @(posedge vga_clk);
    if (en && reset_n) n++;
    @(negedge vga_clk);
    if (prev_fc == 8'd255 && s_fc == 8'd0) wraps++;
    check_both();
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{adv: 1,  exp: mk(0, 0, 1, 1, 1, 1, 1)};
    vecs[1]  = '{adv: 7,  exp: mk(7, 0, 1, 1, 1, 0, 1)};
    vecs[2]  = '{adv: 1,  exp: mk(8, 0, 0, 1, 1, 0, 1)};
    vecs[3]  = '{adv: 2,  exp: mk(10, 0, 0, 0, 1, 0, 1)};
    vecs[4]  = '{adv: 2,  exp: mk(12, 0, 0, 0, 1, 0, 1)};
    vecs[5]  = '{adv: 1,  exp: mk(13, 0, 0, 1, 1, 0, 1)};
    vecs[6]  = '{adv: 2,  exp: mk(0, 1, 1, 1, 1, 0, 1)};
    vecs[7]  = '{adv: 90, exp: mk(0, 7, 0, 1, 0, 0, 1)};
    vecs[8]  = '{adv: 30, exp: mk(0, 9, 0, 1, 1, 0, 1)};
    vecs[9]  = '{adv: 14, exp: mk(14, 9, 0, 1, 1, 0, 1)};
    vecs[10] = '{adv: 1,  exp: mk(0, 0, 1, 1, 1, 1, 2)};

    // Reset held with pix_en high: outputs must stay at reset values.
    @(negedge vga_clk);
    for (int i = 0; i < 4; i++) tick(1'b1);
    cmp("reset_hold", small_out(), mk(0, 0, 0, 1, 1, 0, 0));

    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < vecs[i].adv; k++) tick(1'b1);
      cmp($sformatf("vec%0d", i), small_out(), vecs[i].exp);
    end

    // Stall on the last visible pixel of the small raster (x=7, y=5).
    for (int i = 0; i < 82; i++) tick(1'b1);
    cmp("stall_pre", small_out(), mk(7, 5, 1, 1, 1, 0, 2));
    for (int i = 0; i < 37; i++) tick(1'b0);
    cmp("stall_hold", small_out(), mk(7, 5, 1, 1, 1, 0, 2));
    tick(1'b1);
    cmp("stall_resume", small_out(), mk(8, 5, 0, 1, 1, 0, 2));

    // Asynchronous reset between edges mid-frame.
    for (int i = 0; i < 100; i++) tick(1'b1);
    cmp("pre_async", small_out(), mk(3, 2, 1, 1, 1, 0, 3));
    #2 reset_n = 1'b0;
    #1;
    n = 0;
    cmp("async_small", small_out(), mk(0, 0, 0, 1, 1, 0, 0));
    cmp("async_dflt", dflt_out(), mk(0, 0, 0, 1, 1, 0, 0));
    @(negedge vga_clk);
    for (int i = 0; i < 3; i++) tick(1'b1);
    reset_n = 1'b1;
    tick(1'b1);
    cmp("post_release", small_out(), mk(0, 0, 1, 1, 1, 1, 1));

    // Random enable pattern over enough frames to wrap frame_count.
    for (int i = 0; i < 60000; i++) tick($urandom_range(3) != 0);
    checks++;
    if (wraps < 1) begin
      errors++;
      $display("FAIL fc_wrap got wraps=%0d required >=1", wraps);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
